// File: rtl/sync_pulse_bank.sv
// sync_pulse_bank: synchronises per-channel event levels from foreign clock domains,
// regenerates one-cycle pulses and keeps saturating per-channel pending-event counts.
//   clk       sole clock, rising edge
//   reset     synchronous, active-high
//   in_tog    asynchronous event levels, one per channel
//   ack       pop one pending event per channel
//   ovfl_clr  clears all sticky overflow bits
//   ready     priming complete, events counted only while high
//   out_pulse one-cycle pulse per detected event
//   pend      channel count is non-zero
//   ovfl      sticky overflow per channel
//   cnt       pending counts, channel i at [i*CNTW +: CNTW]
module sync_pulse_bank #(
    parameter int NCH   = 4,
    parameter int NSYNC = 2,
    parameter int CNTW  = 4,
    parameter int MODE  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH-1:0]      in_tog,
    input  logic [NCH-1:0]      ack,
    input  logic                ovfl_clr,
    output logic                ready,
    output logic [NCH-1:0]      out_pulse,
    output logic [NCH-1:0]      pend,
    output logic [NCH-1:0]      ovfl,
    output logic [NCH*CNTW-1:0] cnt
);
    localparam int IW = $clog2(NSYNC + 1);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nx;
    logic [IW-1:0] init_cnt, init_cnt_nx;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= init_cnt_nx;
        end
    end
    // Priming: NSYNC+1 cycles let the chain and prev absorb the present input level.
    always_comb begin
        state_nx    = state;
        init_cnt_nx = init_cnt;
        if (state == INIT) begin
            if (init_cnt == IW'(NSYNC)) state_nx = RUN;
            else init_cnt_nx = init_cnt + 1'b1;
        end
    end
    assign ready = state == RUN;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [NSYNC-1:0] s;
        logic             prev, evt, inc, dec, full, p, o;
        logic [CNTW-1:0]  c;
        assign evt  = (MODE == 0) ? s[NSYNC-1] ^ prev : s[NSYNC-1] & ~prev;
        assign inc  = evt & ready;
        assign dec  = ack[i] & (|c);
        assign full = &c;
        always_ff @(posedge clk) begin
            if (reset) begin
                s    <= '0;
                prev <= 1'b0;
                p    <= 1'b0;
                o    <= 1'b0;
                c    <= '0;
            end else begin
                s    <= {s[NSYNC-2:0], in_tog[i]};
                prev <= s[NSYNC-1];
                p    <= inc;
                c    <= (inc & ~dec & ~full) ? c + 1'b1 : (~inc & dec) ? c - 1'b1 : c;
                // a new overflow beats a simultaneous clear
                o    <= (inc & ~dec & full) | (o & ~ovfl_clr);
            end
        end
        assign out_pulse[i]          = p;
        assign ovfl[i]               = o;
        assign pend[i]               = |c;
        assign cnt[i*CNTW +: CNTW]   = c;
    end
endmodule

// File: tb/tb_sync_pulse_bank.sv
// tb_sync_pulse_bank: directed table-driven and sequence checks for sync_pulse_bank.
module tb_sync_pulse_bank;
    logic        clk = 0, reset = 1, ovfl_clr = 0;
    logic [3:0]  in_tog = 4'hF, ack = 0, in_tog1 = 0, ack1 = 0;
    logic        ready, ready1;
    logic [3:0]  out_pulse, pend, ovfl, out_pulse1, pend1, ovfl1;
    logic [15:0] cnt, cnt1;
    int          checks = 0, failures = 0;

    sync_pulse_bank #(.NCH(4), .NSYNC(2), .CNTW(4), .MODE(0)) dut (
        .clk(clk), .reset(reset), .in_tog(in_tog), .ack(ack), .ovfl_clr(ovfl_clr),
        .ready(ready), .out_pulse(out_pulse), .pend(pend), .ovfl(ovfl), .cnt(cnt));
    sync_pulse_bank #(.NCH(4), .NSYNC(2), .CNTW(4), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .in_tog(in_tog1), .ack(ack1), .ovfl_clr(ovfl_clr),
        .ready(ready1), .out_pulse(out_pulse1), .pend(pend1), .ovfl(ovfl1), .cnt(cnt1));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tog, ack, pulse, ovfl;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[12];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pend_of(input logic [15:0] c);
        for (int k = 0; k < 4; k++) pend_of[k] = c[k*4 +: 4] != 0;
    endfunction

    initial begin
        int np;
        tbl[0]  = '{tog: 4'hE, ack: 4'h0, pulse: 4'h0, ovfl: 4'h0, cnt: 16'h0000};
        tbl[1]  = '{tog: 4'hE, ack: 4'h0, pulse: 4'h0, ovfl: 4'h0, cnt: 16'h0000};
        tbl[2]  = '{tog: 4'hE, ack: 4'h0, pulse: 4'h1, ovfl: 4'h0, cnt: 16'h0001};
        tbl[3]  = '{tog: 4'hE, ack: 4'h0, pulse: 4'h0, ovfl: 4'h0, cnt: 16'h0001};
        tbl[4]  = '{tog: 4'hC, ack: 4'h0, pulse: 4'h0, ovfl: 4'h0, cnt: 16'h0001};
        tbl[5]  = '{tog: 4'hC, ack: 4'h0, pulse: 4'h0, ovfl: 4'h0, cnt: 16'h0001};
        tbl[6]  = '{tog: 4'hC, ack: 4'h0, pulse: 4'h2, ovfl: 4'h0, cnt: 16'h0011};
        tbl[7]  = '{tog: 4'h0, ack: 4'h0, pulse: 4'h0, ovfl: 4'h0, cnt: 16'h0011};
        tbl[8]  = '{tog: 4'h0, ack: 4'h0, pulse: 4'h0, ovfl: 4'h0, cnt: 16'h0011};
        tbl[9]  = '{tog: 4'h0, ack: 4'h0, pulse: 4'hC, ovfl: 4'h0, cnt: 16'h1111};
        tbl[10] = '{tog: 4'h0, ack: 4'hF, pulse: 4'h0, ovfl: 4'h0, cnt: 16'h0000};
        tbl[11] = '{tog: 4'h0, ack: 4'hF, pulse: 4'h0, ovfl: 4'h0, cnt: 16'h0000};

        // reset state with all inputs held high
        step();
        step();
        chk("rst_ready", 32'(ready), 0);
        chk("rst_pulse", 32'(out_pulse), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_ovfl", 32'(ovfl), 0);
        chk("rst_pend", 32'(pend), 0);
        reset = 0;
        step();
        chk("prime_e1", 32'(ready), 0);
        step();
        chk("prime_e2", 32'(ready), 0);
        step();
        chk("prime_e3", 32'(ready), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("high_level_no_pulse", 32'(out_pulse), 0);
            chk("high_level_no_cnt", 32'(cnt), 0);
        end

        // table: single toggle, second channel, simultaneous events, acks
        for (int v = 0; v < 12; v++) begin
            in_tog = tbl[v].tog;
            ack    = tbl[v].ack;
            step();
            chk($sformatf("tbl%0d_pulse", v), 32'(out_pulse), 32'(tbl[v].pulse));
            chk($sformatf("tbl%0d_cnt", v), 32'(cnt), 32'(tbl[v].cnt));
            chk($sformatf("tbl%0d_pend", v), 32'(pend), 32'(pend_of(tbl[v].cnt)));
            chk($sformatf("tbl%0d_ovfl", v), 32'(ovfl), 32'(tbl[v].ovfl));
        end
        ack = 0;

        // saturation on ch1
        for (int k = 1; k <= 17; k++) begin
            in_tog[1] = ~in_tog[1];
            step();
            step();
            step();
            chk("sat_pulse", 32'(out_pulse), 4'h2);
            chk("sat_cnt", 32'(cnt[7:4]), (k > 15) ? 15 : k);
            chk("sat_ovfl", 32'(ovfl[1]), 32'(k > 15));
        end
        ovfl_clr = 1;
        step();
        ovfl_clr = 0;
        chk("clr_ovfl", 32'(ovfl), 0);
        chk("clr_cnt_kept", 32'(cnt[7:4]), 15);
        in_tog[1] = ~in_tog[1];
        step();
        step();
        ovfl_clr = 1;
        step();
        ovfl_clr = 0;
        chk("set_wins", 32'(ovfl), 4'h2);
        ovfl_clr = 1;
        step();
        ovfl_clr = 0;
        chk("clr_again", 32'(ovfl), 0);

        // inc and dec together on ch2
        in_tog[2] = ~in_tog[2];
        step();
        step();
        step();
        chk("ch2_one", 32'(cnt[11:8]), 1);
        in_tog[2] = ~in_tog[2];
        step();
        step();
        ack = 4'h4;
        step();
        ack = 0;
        chk("incdec_cnt", 32'(cnt[11:8]), 1);
        chk("incdec_pulse", 32'(out_pulse), 4'h4);
        ack = 4'h4;
        step();
        chk("ack_to_zero", 32'(cnt[11:8]), 0);
        step();
        ack = 0;
        chk("ack_empty", 32'(cnt[11:8]), 0);
        chk("ack_empty_pend", 32'(pend[2]), 0);
        chk("ch1_untouched", 32'(cnt[7:4]), 15);

        // rising-edge mode: one event for a full high pulse on ch3
        np = 0;
        in_tog1[3] = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            np += int'(out_pulse1[3]);
        end
        in_tog1[3] = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            np += int'(out_pulse1[3]);
        end
        chk("mode1_pulses", 32'(np), 1);
        chk("mode1_cnt", 32'(cnt1), 16'h1000);

        // reset mid-operation with cnt0=5 and ovfl0 set
        for (int k = 0; k < 16; k++) begin
            in_tog[0] = ~in_tog[0];
            step();
            step();
            step();
        end
        ack = 4'h1;
        for (int k = 0; k < 10; k++) step();
        ack = 0;
        chk("pre_rst_cnt0", 32'(cnt[3:0]), 5);
        chk("pre_rst_ovfl", 32'(ovfl), 4'h1);
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_cnt", 32'(cnt), 0);
        chk("mid_rst_ovfl", 32'(ovfl), 0);
        chk("mid_rst_pend", 32'(pend), 0);
        chk("mid_rst_ready", 32'(ready), 0);
        in_tog[0] = ~in_tog[0];
        in_tog[3] = ~in_tog[3];
        step();
        chk("init_e1", 32'(ready), 0);
        step();
        chk("init_e2", 32'(ready), 0);
        step();
        chk("init_e3", 32'(ready), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("init_tog_no_pulse", 32'(out_pulse), 0);
        end
        chk("init_tog_no_cnt", 32'(cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
